// File: rtl/sdc_user_responder.sv
// Stand-in for the SDRAM controller core: answers user requests from an internal
// word-addressed RAM with the same handshake timing as the real controller.
module sdc_user_responder #(
    parameter int DEPTH_LOG2 = 9,
    parameter int INIT_CYC   = 16,
    parameter int RD_LAT     = 3
) (
    input  logic        sdc_clk,
    input  logic        s_reset,
    input  logic        sdc_en,
    input  logic        sdc_req,
    input  logic [22:0] sdc_req_adr,
    input  logic [1:0]  sdc_req_len,
    input  logic        sdc_req_wr_n,
    input  logic [31:0] sdc_wr_data,
    input  logic [3:0]  sdc_wr_en_n,
    output logic        sdc_req_ack,
    output logic        sdc_wr_next,
    output logic [31:0] sdc_rd_data,
    output logic        sdc_rd_valid,
    output logic        sdc_init_done
);

    // state    | meaning
    // INIT     | post-reset delay, requests ignored
    // IDLE     | waiting for sdc_req & sdc_en
    // ACK      | ack pulse, request fields latched
    // WR       | pulling N write beats
    // RD_WAIT  | read latency countdown
    // RD       | returning N read beats
    localparam logic [2:0] S_INIT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_ACK     = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_RD_WAIT = 3'd4;
    localparam logic [2:0] S_RD      = 3'd5;

    localparam int INIT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;
    localparam int LAT_W  = 4;

    logic [2:0]            state;
    logic [INIT_W-1:0]     init_cnt;
    logic [LAT_W-1:0]      lat_cnt;
    logic [DEPTH_LOG2-1:0] addr;
    logic [1:0]            len_q;
    logic                  wr_n_q;
    logic [5:0]            beat;
    logic [5:0]            n_m1;
    logic                  last_beat;
    logic                  mem_we;
    logic                  unused_adr_hi;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    assign n_m1          = (6'd4 << len_q) - 6'd1;
    assign last_beat     = (beat == n_m1);
    assign mem_we        = (state == S_WR) && !s_reset;
    assign unused_adr_hi = ^sdc_req_adr[22:DEPTH_LOG2];

    always_ff @(posedge sdc_clk) begin
        if (s_reset) begin
            state         <= S_INIT;
            init_cnt      <= INIT_W'(INIT_CYC - 1);
            lat_cnt       <= '0;
            addr          <= '0;
            len_q         <= '0;
            wr_n_q        <= 1'b0;
            beat          <= '0;
            sdc_req_ack   <= 1'b0;
            sdc_wr_next   <= 1'b0;
            sdc_rd_valid  <= 1'b0;
            sdc_rd_data   <= '0;
            sdc_init_done <= 1'b0;
        end else begin
            sdc_req_ack <= 1'b0;
            case (state)
                S_INIT: begin
                    if (init_cnt == '0) begin
                        state         <= S_IDLE;
                        sdc_init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (sdc_req && sdc_en) begin
                        state       <= S_ACK;
                        sdc_req_ack <= 1'b1;
                        addr        <= sdc_req_adr[DEPTH_LOG2-1:0];
                        len_q       <= sdc_req_len;
                        wr_n_q      <= sdc_req_wr_n;
                        beat        <= '0;
                        lat_cnt     <= LAT_W'(RD_LAT - 1);
                    end
                end
                S_ACK, S_RD_WAIT: begin
                    // The latency count already covers the ACK cycle itself.
                    if (state == S_ACK && !wr_n_q) begin
                        state       <= S_WR;
                        sdc_wr_next <= 1'b1;
                    end else if (lat_cnt == '0) begin
                        state        <= S_RD;
                        sdc_rd_valid <= 1'b1;
                        sdc_rd_data  <= mem[addr];
                        addr         <= addr + 1'b1;
                    end else begin
                        state   <= S_RD_WAIT;
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                S_WR: begin
                    addr <= addr + 1'b1;
                    if (last_beat) begin
                        state       <= S_IDLE;
                        sdc_wr_next <= 1'b0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                S_RD: begin
                    if (last_beat) begin
                        state        <= S_IDLE;
                        sdc_rd_valid <= 1'b0;
                    end else begin
                        beat        <= beat + 1'b1;
                        sdc_rd_data <= mem[addr];
                        addr        <= addr + 1'b1;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // RAM has no reset so its contents survive s_reset.
    always_ff @(posedge sdc_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (!sdc_wr_en_n[i]) mem[addr][8*i +: 8] <= sdc_wr_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sdc_user_responder.sv
// Directed and randomized bench for sdc_user_responder against a byte-level
// memory model with per-byte known flags.
module tb_sdc_user_responder;

    localparam int DEPTH_LOG2 = 9;
    localparam int INIT_CYC   = 16;
    localparam int RD_LAT     = 3;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic        sdc_clk = 1'b0;
    logic        s_reset;
    logic        sdc_en;
    logic        sdc_req;
    logic [22:0] sdc_req_adr;
    logic [1:0]  sdc_req_len;
    logic        sdc_req_wr_n;
    logic [31:0] sdc_wr_data;
    logic [3:0]  sdc_wr_en_n;
    logic        sdc_req_ack;
    logic        sdc_wr_next;
    logic [31:0] sdc_rd_data;
    logic        sdc_rd_valid;
    logic        sdc_init_done;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_m [DEPTH];
    logic [3:0]  vld_m [DEPTH];

    sdc_user_responder #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .INIT_CYC  (INIT_CYC),
        .RD_LAT    (RD_LAT)
    ) dut (
        .sdc_clk      (sdc_clk),
        .s_reset      (s_reset),
        .sdc_en       (sdc_en),
        .sdc_req      (sdc_req),
        .sdc_req_adr  (sdc_req_adr),
        .sdc_req_len  (sdc_req_len),
        .sdc_req_wr_n (sdc_req_wr_n),
        .sdc_wr_data  (sdc_wr_data),
        .sdc_wr_en_n  (sdc_wr_en_n),
        .sdc_req_ack  (sdc_req_ack),
        .sdc_wr_next  (sdc_wr_next),
        .sdc_rd_data  (sdc_rd_data),
        .sdc_rd_valid (sdc_rd_valid),
        .sdc_init_done(sdc_init_done)
    );

    always #5 sdc_clk = ~sdc_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] v);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = v[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    // Raise a request (optionally held off by sdc_en=0 first) and expect the ack one cycle later.
    task automatic issue(input logic [22:0] adr, input logic [1:0] len, input logic wr_n, input int gate);
        int n;
        sdc_req      = 1'b1;
        sdc_req_adr  = adr;
        sdc_req_len  = len;
        sdc_req_wr_n = wr_n;
        if (gate > 0) begin
            sdc_en = 1'b0;
            for (int i = 0; i < gate; i++) begin
                @(negedge sdc_clk);
                chk("gate_no_ack", sdc_req_ack, 1'b0);
            end
            sdc_en = 1'b1;
        end
        n = 0;
        do begin
            @(negedge sdc_clk);
            n++;
        end while (!sdc_req_ack && n < 100);
        chk("ack_latency", n, 1);
        sdc_req = 1'b0;
    endtask

    // mode 0: random data/mask, 1: data = beat index, 2: fixed data/mask
    task automatic do_write(input logic [22:0] adr, input logic [1:0] len, input int gate,
                            input bit en_drop, input int rst_beat, input int mode,
                            input logic [31:0] fdata, input logic [3:0] fmask);
        int nb;
        int idx;
        bit aborted;
        nb = 4 << len;
        aborted = 1'b0;
        issue(adr, len, 1'b0, gate);
        if (en_drop) sdc_en = 1'b0;
        for (int b = 0; b < nb; b++) begin
            @(negedge sdc_clk);
            if (b == 0) chk("wr_ack_pulse", sdc_req_ack, 1'b0);
            chk("wr_next_high", sdc_wr_next, 1'b1);
            idx = int'((adr + 23'(b)) % DEPTH);
            if (b == rst_beat) begin
                s_reset = 1'b1;
                vld_m[idx] = 4'h0;
                aborted = 1'b1;
                break;
            end
            case (mode)
                1:       begin sdc_wr_data = 32'(b); sdc_wr_en_n = 4'h0; end
                2:       begin sdc_wr_data = fdata;  sdc_wr_en_n = fmask; end
                default: begin
                    sdc_wr_data = $urandom;
                    sdc_wr_en_n = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                end
            endcase
            for (int i = 0; i < 4; i++) begin
                if (!sdc_wr_en_n[i]) begin
                    mem_m[idx][8*i +: 8] = sdc_wr_data[8*i +: 8];
                    vld_m[idx][i] = 1'b1;
                end
            end
        end
        @(negedge sdc_clk);
        chk("wr_next_low_after", sdc_wr_next, 1'b0);
        if (aborted) begin
            chk("abort_init_done", sdc_init_done, 1'b0);
            chk("abort_no_ack", sdc_req_ack, 1'b0);
            s_reset = 1'b0;
        end
        sdc_en = 1'b1;
    endtask

    task automatic do_read(input logic [22:0] adr, input logic [1:0] len, input int gate, input bit en_drop);
        int nb;
        int idx;
        logic [31:0] bm;
        logic [31:0] last;
        nb = 4 << len;
        issue(adr, len, 1'b1, gate);
        if (en_drop) sdc_en = 1'b0;
        for (int c = 0; c < RD_LAT - 1; c++) begin
            @(negedge sdc_clk);
            chk("rd_wait_invalid", sdc_rd_valid, 1'b0);
        end
        for (int b = 0; b < nb; b++) begin
            @(negedge sdc_clk);
            if (b == 0) chk("rd_ack_pulse", sdc_req_ack, 1'b0);
            chk("rd_valid_high", sdc_rd_valid, 1'b1);
            idx = int'((adr + 23'(b)) % DEPTH);
            bm = byte_mask(vld_m[idx]);
            chk("rd_data", sdc_rd_data & bm, mem_m[idx] & bm);
        end
        last = sdc_rd_data;
        @(negedge sdc_clk);
        chk("rd_valid_low_after", sdc_rd_valid, 1'b0);
        chk("rd_data_hold", sdc_rd_data, last);
        sdc_en = 1'b1;
    endtask

    initial begin
        int n;
        logic [22:0] a;
        logic [1:0]  l;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            vld_m[i] = 4'h0;
        end
        s_reset      = 1'b1;
        sdc_en       = 1'b1;
        sdc_req      = 1'b1;
        sdc_req_adr  = '0;
        sdc_req_len  = '0;
        sdc_req_wr_n = 1'b1;
        sdc_wr_data  = '0;
        sdc_wr_en_n  = 4'h0;

        // Reset held 5 cycles with a request pending.
        for (int i = 0; i < 5; i++) begin
            @(negedge sdc_clk);
            chk("rst_ack", sdc_req_ack, 1'b0);
            chk("rst_wr_next", sdc_wr_next, 1'b0);
            chk("rst_rd_valid", sdc_rd_valid, 1'b0);
            chk("rst_rd_data", sdc_rd_data, 32'h0);
            chk("rst_init_done", sdc_init_done, 1'b0);
        end
        s_reset = 1'b0;
        for (int i = 1; i <= INIT_CYC; i++) begin
            @(negedge sdc_clk);
            chk("init_done_timing", sdc_init_done, (i >= INIT_CYC) ? 1'b1 : 1'b0);
            chk("init_no_ack", sdc_req_ack, 1'b0);
            chk("init_wr_next", sdc_wr_next, 1'b0);
            chk("init_rd_valid", sdc_rd_valid, 1'b0);
            chk("init_rd_data", sdc_rd_data, 32'h0);
        end
        sdc_req = 1'b0;
        @(negedge sdc_clk);
        chk("post_init_no_ack", sdc_req_ack, 1'b0);
        chk("init_done_level", sdc_init_done, 1'b1);

        // len 0 at 0x200 (upper address bit ignored), data 0..3
        do_write(23'h200, 2'd0, 0, 1'b0, -1, 1, 32'h0, 4'h0);
        do_read(23'h200, 2'd0, 0, 1'b0);
        chk("len0_word3", mem_m[3], 32'h3);

        // Length sweep across the 0x1FF -> 0x000 wrap
        for (int k = 1; k <= 3; k++) begin
            do_write(23'h1F8, 2'(k), 0, 1'b0, -1, 0, 32'h0, 4'h0);
            do_read(23'h1F8, 2'(k), 0, 1'b0);
        end

        // Byte masks, including a fully masked beat
        a = 23'($urandom_range(0, DEPTH - 1));
        do_write(a, 2'd0, 0, 1'b0, -1, 2, 32'hFFFF_FFFF, 4'h0);
        do_write(a, 2'd0, 0, 1'b0, -1, 2, 32'h0000_0000, 4'b1010);
        do_write(a, 2'd0, 0, 1'b0, -1, 2, 32'h1234_5678, 4'hF);
        do_read(a, 2'd0, 0, 1'b0);
        chk("mask_model", mem_m[int'(a % DEPTH)], 32'hFF00_FF00);

        // sdc_en gating before accept; sdc_en dropped mid-burst
        do_write(23'h040, 2'd1, 20, 1'b1, -1, 0, 32'h0, 4'h0);
        do_read(23'h040, 2'd1, 20, 1'b1);

        // Randomized back-to-back traffic
        for (int k = 0; k < 12; k++) begin
            a = 23'($urandom);
            l = 2'($urandom_range(0, 3));
            do_write(a, l, 0, 1'($urandom_range(0, 1)), -1, 0, 32'h0, 4'h0);
            if ($urandom_range(0, 1) == 1) a = a + 23'($urandom_range(0, 8));
            do_read(a, 2'($urandom_range(0, 3)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        // Reset during beat 5 of a 16-word write; earlier beats and the old tail persist
        a = 23'h0A0;
        do_write(a, 2'd2, 0, 1'b0, -1, 0, 32'h0, 4'h0);
        do_write(a, 2'd2, 0, 1'b0, 4, 0, 32'h0, 4'h0);
        n = 0;
        while (!sdc_init_done && n < 100) begin
            @(negedge sdc_clk);
            n++;
        end
        chk("reinit_latency", n, INIT_CYC);
        do_read(a, 2'd2, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdc_user_responder.md
# sdc_user_responder

Synthesizable responder for the SDRAM controller user-request interface, on the side that answers `sdc_req`. It accepts requests, pulses `sdc_req_ack`, pulls write data with `sdc_wr_next` and returns read data with `sdc_rd_valid`. Storage is an internal word-addressed RAM. It stands in for the controller core so that the request agent, and any other user-side master, can be run and regression-checked without a DRAM model. It also provides `sdc_init_done` sequencing after reset.

## Interface
Parameters:
- `DEPTH_LOG2`, 9: log2 of the internal RAM depth in 32-bit words (512 words).
- `INIT_CYC`, 16: cycles from reset release to `sdc_init_done`.
- `RD_LAT`, 3: cycles from the ack cycle to the first `sdc_rd_valid`; legal range 1..15.

Ports:
- `sdc_clk`, in, 1: the only clock; all logic is on the rising edge.
- `s_reset`, in, 1: synchronous, active-high reset.
- `sdc_en`, in, 1: when 0, no new request is accepted. A burst already in progress finishes.
- `sdc_req`, in, 1: request, held high by the master until it sees the ack.
- `sdc_req_adr`, in, 23: word address. Bits [DEPTH_LOG2-1:0] index the RAM; upper bits are ignored.
- `sdc_req_len`, in, 2: burst length code. The number of words is N = 4 << len, giving 4, 8, 16 or 32.
- `sdc_req_wr_n`, in, 1: 0 = write, 1 = read.
- `sdc_wr_data`, in, 32: write data.
- `sdc_wr_en_n`, in, 4: active-low byte enables; bit i controls byte i.
- `sdc_req_ack`, out, 1: one-cycle acceptance pulse.
- `sdc_wr_next`, out, 1: write-data strobe.
- `sdc_rd_data`, out, 32: read data.
- `sdc_rd_valid`, out, 1: read-data qualifier.
- `sdc_init_done`, out, 1: initialisation complete, level.

## Operation
State machine: INIT, IDLE, ACK, WR, RD_WAIT, RD.
- **INIT**: an internal counter runs for INIT_CYC cycles, then the machine goes to IDLE and `sdc_init_done` is set. `sdc_init_done` stays at 1 until the next reset. Any `sdc_req` during INIT is ignored and gets no ack.
- **IDLE**: if `sdc_req & sdc_en` at a clock edge, the machine goes to ACK and latches address, length and wr_n at that edge.
- **ACK**: `sdc_req_ack` = 1 for exactly this cycle. Next state is WR if wr_n = 0, otherwise RD_WAIT.
- **WR**:
  - `sdc_wr_next` = 1 for N consecutive cycles.
  - On every edge where `sdc_wr_next` = 1, the word at `sdc_wr_data` is written to RAM[addr] under byte enables `~sdc_wr_en_n`. The address then increments.
  - After beat N the machine returns to IDLE.
- **RD_WAIT**: waits until RD_LAT cycles have elapsed since the ACK cycle.
- **RD**: `sdc_rd_valid` = 1 for N consecutive cycles, each carrying RAM[addr] with addr incrementing. After the last beat the machine returns to IDLE.

Address and width rules:
- The burst address is a DEPTH_LOG2-bit counter and wraps modulo 2^DEPTH_LOG2 (511 → 0).
- There is no row or bank boundary handling.
- The beat counter is 6 bits and compares against N - 1.

Boundary conditions:
- `sdc_req` still high in the first IDLE cycle after a burst is treated as a new request. Masters must drop `sdc_req` after the ack.
- `sdc_en` falling during WR, RD_WAIT or RD does not abort the burst; it only blocks the next accept.
- A mask of 4'hF on a beat consumes that beat (address advances) but leaves the RAM unchanged.
- A read of a never-written location returns whatever the RAM holds; RAM is not cleared at reset.
- Reset mid-burst: the next state is INIT, all outputs are forced to reset values, the partial write stays in RAM, and there is no ack.

## Timing
Reset values: `sdc_req_ack`, `sdc_wr_next`, `sdc_rd_valid` and `sdc_init_done` = 0; `sdc_rd_data` = 0.

All outputs are registered. `sdc_rd_data` holds its last value when `sdc_rd_valid` = 0.

Latencies, measured from the edge where `sdc_req` is sampled in IDLE (call it edge T):
- Ack: `sdc_req_ack` is high during cycle T+1.
- Write: `sdc_wr_next` is high in cycles T+2 .. T+1+N. Data is sampled at the end of each of those cycles.
- Read: `sdc_rd_valid` is high in cycles T+1+RD_LAT .. T+RD_LAT+N.
- Back-to-back: the earliest next accept edge is the end of the first IDLE cycle after the last beat, so there is a minimum one-cycle bubble between bursts.

Init: `sdc_init_done` rises at cycle INIT_CYC + 1 after the last cycle with `s_reset` = 1.

## Test plan
- **Reset / init**: hold `s_reset` 5 cycles with `sdc_req` = 1, then release. Required: no ack during INIT; `sdc_init_done` rises exactly INIT_CYC + 1 cycles after release; all other outputs stay 0 throughout.
- **Write then read, len 0**: write 4 words at addr 0x200 with data 0..3, then read the same address. Required: ack 1 cycle after accept; `sdc_wr_next` high 4 cycles; `sdc_rd_valid` high 4 cycles starting RD_LAT after the read ack; data 0,1,2,3.
- **Length sweep and wrap**: for len = 1, 2, 3, write at addr 0x1F8 and read back. Required: 8, 16 and 32 beats respectively; addresses wrap past 0x1FF to 0x000; read data equals written data.
- **Byte masks**: write 0xFFFFFFFF to 4 words, then write 0x00000000 with `sdc_wr_en_n` = 4'b1010. Required: readback is 0xFF00FF00 on every word.
- **`sdc_en` gating and mid-burst reset**: with `sdc_en` = 0, a held `sdc_req` gets no ack for 20 cycles; raising `sdc_en` gives an ack 1 cycle later. Asserting `s_reset` during beat 5 of a 16-word write drops `sdc_wr_next` the next cycle and re-enters INIT.
